ahb_mem_slave: RTL and testbench
================================

# ahb_mem_slave

AHB-Lite subordinate that consumes the `s_ahb_mosi_t` request bundle and produces the `s_ahb_miso_t` response bundle from `amba_ahb_pkg`. It backs a register-array memory for simulation and small on-chip scratch storage. It sits directly downstream of a single AHB manager on a point-to-point link, with no interconnect or mux. It supports configurable wait states, byte/halfword/word accesses, and the two-cycle ERROR response.

## Interface
- `MEM_WORDS`, default 1024: memory depth in 32-bit words; power of two, from 16 to 65536.
- `BASE_ADDR`, default 32'h0000_0000: byte base address; must be aligned to 4*`MEM_WORDS`.
- `WAIT_STATES`, default 0: wait cycles inserted in every OKAY data phase; range 0..15.
- `hclk`, input, 1: the only clock; all logic is on the rising edge.
- `hresetn`, input, 1: reset, synchronous and active-low.
- `ahb_mosi_i`, input, `s_ahb_mosi_t`: request from the manager.
- `ahb_miso_o`, output, `s_ahb_miso_t`: response to the manager.

## Operation
- **Acceptance.** The link is point-to-point, so the block's own `hready` output serves as HREADYIN.
  - An address phase is accepted on a rising edge where `hsel`=1, `htrans` is NONSEQUENTIAL or SEQUENTIAL, and `hready`=1.
  - IDLE or BUSY, or `hsel`=0, is not a transfer: no memory access, and the response is OKAY with zero wait.
- **Ignored fields.** `hburst`, `hprot`, `hmastlock`, `hnonsec`, `hmaster` and `hexcl` are ignored. Bursts are handled as a sequence of single transfers.
- **Captured at acceptance.** `haddr`, `hsize`, `hwrite`, and an error flag.
- **Error flag** is set if any of the following holds:
  - the address is outside [`BASE_ADDR`, `BASE_ADDR`+4*`MEM_WORDS`-1];
  - `hsize` > AHB_SZ_WORD;
  - the address is misaligned: `haddr[0]`≠0 for HWORD, or `haddr[1:0]`≠0 for WORD.
- **Word index.** (`haddr`-`BASE_ADDR`)[log2(`MEM_WORDS`)+1:2].
- **Byte lanes** are little-endian.
  - BYTE: lane `haddr[1:0]`.
  - HWORD: lanes {`haddr[1]`,0} and {`haddr[1]`,1}.
  - WORD: all four lanes.
- **Writes** update only the selected lanes with `hwdata` sampled on the final data-phase edge, i.e. where `hready`=1. Erroring transfers never write.
- **Reads** return the full 32-bit word on `hrdata` in the final data-phase cycle; the manager selects the lanes. `hrdata`=0 in every other cycle.
- **Memory is not reset**; its contents after reset are undefined.
- **Exclusive access is unsupported**: `hexokay` is tied to 0.
- **FSM states:**
  - IDLE: no data phase pending. `hready`=1, `hresp`=0.
  - WAIT: OKAY data phase with `wcnt`>0. `hready`=0, `hresp`=0.
  - DATA: final OKAY data-phase cycle. `hready`=1, `hresp`=0.
  - ERR1: `hready`=0, `hresp`=1.
  - ERR2: `hready`=1, `hresp`=1.
- **FSM transitions:**
  - IDLE, DATA or ERR2 (all cycles with `hready`=1), on an accepted transfer:
    - error → ERR1;
    - else if `WAIT_STATES`=0 → DATA;
    - else → WAIT with `wcnt`=`WAIT_STATES`.
  - Same states with no accepted transfer → IDLE.
  - WAIT: `wcnt` decrements each cycle; at `wcnt`=1, next state is DATA.
  - ERR1 → ERR2 unconditionally. The address bus is not sampled during ERR1.
- **Address/data overlap.** In DATA and ERR2 the next address phase is accepted in the same cycle as the current data phase completes, giving back-to-back pipelining.
- **Read-after-write.** A write commits at the edge ending its data phase. A following read's data phase is always at least one cycle later, so it sees the new data and no forwarding is needed.
- **Reset.** When `hresetn`=0 at an edge: state→IDLE, `wcnt`→0, captured address/control cleared. Any pending transfer is discarded and never writes memory.

## Timing
- **Output values.** `hresp` and `hready` come from state registers. `hrdata` is combinational from the memory array and the captured index.
- **Reset values:** `hready`=1, `hresp`=0, `hrdata`=0, `hexokay`=0.
- **OKAY transfer.** Address accepted at edge E. Data phase spans cycles E+1 .. E+1+`WAIT_STATES`. `hready`=1 only in the last of those cycles. Read data and write data are both valid in that last cycle.
- **ERROR transfer.** Address accepted at edge E. Cycle E+1 is ERR1; cycle E+2 is ERR2. `WAIT_STATES` does not apply.
- **Throughput.** One transfer per 1+`WAIT_STATES` cycles sustained; one per cycle when `WAIT_STATES`=0.

## Test plan
- **Write/read, `WAIT_STATES`=0.**
  - Stimulus: WORD write of 32'hDEAD_BEEF to `BASE_ADDR`+8, immediately followed by a read of the same address.
  - Required: `hready` held at 1 throughout; `hrdata`=32'hDEAD_BEEF one cycle after the read address phase; `hresp`=0.
- **Byte lanes.**
  - Stimulus: WORD write of 32'h0 to offset 0x10, then BYTE write of 8'hAA to offset 0x11, then HWORD write of 16'h1234 to offset 0x12, then WORD read of offset 0x10.
  - Required: read returns 32'h1234_AA00.
- **Wait states, `WAIT_STATES`=3.**
  - Stimulus: single read.
  - Required: `hready`=0 for exactly 3 cycles, then 1 with data valid.
  - Stimulus: back-to-back NONSEQ reads.
  - Required: one completes every 4 cycles.
- **Error response.**
  - Stimulus, one transfer per cycle against the same prior memory contents:
    - out-of-range address `BASE_ADDR`+4*`MEM_WORDS`;
    - WORD access to offset 0x2;
    - AHB_SZ_DWORD access;
    - writes of 32'hFFFF_FFFF at each of these.
  - Required, for each case:
    - ERR1 (`hready`=0, `hresp`=1) then ERR2 (`hready`=1, `hresp`=1);
    - a subsequent read shows memory unchanged.
  - Stimulus: a valid transfer presented during ERR2.
  - Required: it is accepted and completes OKAY.
- **IDLE/BUSY and `hsel`=0.**
  - Stimulus: drive BUSY, IDLE, and NONSEQ with `hsel`=0, each carrying write data.
  - Required: no memory change; `hready`=1; `hresp`=0.
- **Reset mid-transfer.**
  - Stimulus: `WAIT_STATES`=3, deassert `hresetn` during the WAIT state of a write.
  - Required: next cycle `hready`=1 and `hresp`=0; the target word is not written.

Source files
------------

// File: rtl/amba_ahb_pkg.sv
// AHB-Lite request/response bundles and encodings shared by managers and subordinates.
package amba_ahb_pkg;

  localparam logic [1:0] AHB_TRANS_IDLE   = 2'b00;
  localparam logic [1:0] AHB_TRANS_BUSY   = 2'b01;
  localparam logic [1:0] AHB_TRANS_NONSEQ = 2'b10;
  localparam logic [1:0] AHB_TRANS_SEQ    = 2'b11;

  localparam logic [2:0] AHB_SZ_BYTE  = 3'd0;
  localparam logic [2:0] AHB_SZ_HWORD = 3'd1;
  localparam logic [2:0] AHB_SZ_WORD  = 3'd2;
  localparam logic [2:0] AHB_SZ_DWORD = 3'd3;

  typedef struct packed {
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [3:0]  hprot;
    logic        hmastlock;
    logic        hnonsec;
    logic        hwrite;
    logic [31:0] hwdata;
    logic [3:0]  hmaster;
    logic        hexcl;
  } s_ahb_mosi_t;

  typedef struct packed {
    logic        hready;
    logic        hresp;
    logic [31:0] hrdata;
    logic        hexokay;
  } s_ahb_miso_t;

endpackage

// File: rtl/ahb_mem_slave.sv
// AHB-Lite subordinate backed by a register-array memory, with configurable wait states
// and the two-cycle ERROR response.
module ahb_mem_slave
  import amba_ahb_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        hclk,
  input  logic        hresetn,
  input  s_ahb_mosi_t ahb_mosi_i,
  output s_ahb_miso_t ahb_miso_o
);

  localparam int unsigned IdxW     = $clog2(MEM_WORDS);
  localparam logic [3:0]  WaitInit = 4'(WAIT_STATES);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StWait = 3'd1;
  localparam logic [2:0] StData = 3'd2;
  localparam logic [2:0] StErr1 = 3'd3;
  localparam logic [2:0] StErr2 = 3'd4;

  logic [2:0]      state_q, state_d;
  logic [3:0]      wcnt_q, wcnt_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [3:0]      be_q, be_d;
  logic            write_q, write_d;

  logic [31:0] mem_q [MEM_WORDS];

  logic        hready;
  logic        hresp;
  logic        accept;
  logic        addr_err;
  logic [31:0] offset;
  logic [3:0]  byte_en;

  assign hready = (state_q == StIdle) || (state_q == StData) || (state_q == StErr2);
  assign hresp  = (state_q == StErr1) || (state_q == StErr2);

  // Point-to-point link: our own hready doubles as HREADYIN.
  assign accept = ahb_mosi_i.hsel && ahb_mosi_i.htrans[1] && hready;

  // BASE_ADDR is aligned to the window size, so any set bit above the window is out of range.
  assign offset   = ahb_mosi_i.haddr - BASE_ADDR;
  assign addr_err = (|offset[31:IdxW+2])
                  || (ahb_mosi_i.hsize > AHB_SZ_WORD)
                  || ((ahb_mosi_i.hsize == AHB_SZ_HWORD) && ahb_mosi_i.haddr[0])
                  || ((ahb_mosi_i.hsize == AHB_SZ_WORD) && (|ahb_mosi_i.haddr[1:0]));

  always_comb begin
    byte_en = 4'b1111;
    case (ahb_mosi_i.hsize)
      AHB_SZ_BYTE:  byte_en = 4'b0001 << ahb_mosi_i.haddr[1:0];
      AHB_SZ_HWORD: byte_en = ahb_mosi_i.haddr[1] ? 4'b1100 : 4'b0011;
      default:      byte_en = 4'b1111;
    endcase
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    idx_d   = idx_q;
    be_d    = be_q;
    write_d = write_q;
    case (state_q)
      StIdle, StData, StErr2: begin
        if (accept) begin
          idx_d   = offset[IdxW+1:2];
          be_d    = byte_en;
          write_d = ahb_mosi_i.hwrite;
          if (addr_err) begin
            state_d = StErr1;
          end else if (WaitInit == 4'd0) begin
            state_d = StData;
          end else begin
            state_d = StWait;
            wcnt_d  = WaitInit;
          end
        end else begin
          state_d = StIdle;
        end
      end
      StWait: begin
        wcnt_d = wcnt_q - 4'd1;
        if (wcnt_q == 4'd1) begin
          state_d = StData;
        end
      end
      StErr1:  state_d = StErr2;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      state_q <= StIdle;
      wcnt_q  <= 4'd0;
      idx_q   <= '0;
      be_q    <= 4'd0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      idx_q   <= idx_d;
      be_q    <= be_d;
      write_q <= write_d;
    end
  end

  // Memory has no reset; a reset edge must still suppress a pending write.
  always_ff @(posedge hclk) begin
    if (hresetn && (state_q == StData) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) begin
          mem_q[idx_q][8*i +: 8] <= ahb_mosi_i.hwdata[8*i +: 8];
        end
      end
    end
  end

  assign ahb_miso_o.hready  = hready;
  assign ahb_miso_o.hresp   = hresp;
  assign ahb_miso_o.hrdata  = ((state_q == StData) && !write_q) ? mem_q[idx_q] : 32'h0;
  assign ahb_miso_o.hexokay = 1'b0;

  logic unused_fields;
  assign unused_fields = ^{ahb_mosi_i.hburst, ahb_mosi_i.hprot, ahb_mosi_i.hmastlock,
                           ahb_mosi_i.hnonsec, ahb_mosi_i.hmaster, ahb_mosi_i.hexcl,
                           ahb_mosi_i.htrans[0], offset[1:0]};

endmodule

// File: tb/tb_ahb_mem_slave.sv
// Directed bench: a zero-wait instance driven from a vector table and a three-wait instance
// driven by hand-written multi-cycle sequences.
module tb_ahb_mem_slave;
  import amba_ahb_pkg::*;

  localparam logic [31:0] Base = 32'h0000_1000;
  localparam logic [1:0]  TI = AHB_TRANS_IDLE;
  localparam logic [1:0]  TB = AHB_TRANS_BUSY;
  localparam logic [1:0]  TN = AHB_TRANS_NONSEQ;
  localparam logic [1:0]  TS = AHB_TRANS_SEQ;
  localparam logic [2:0]  SB = AHB_SZ_BYTE;
  localparam logic [2:0]  SH = AHB_SZ_HWORD;
  localparam logic [2:0]  SW = AHB_SZ_WORD;
  localparam logic [2:0]  SD = AHB_SZ_DWORD;
  localparam logic [31:0] Ones = 32'hFFFF_FFFF;

  typedef struct {
    logic        sel;
    logic [1:0]  tr;
    logic        wr;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        er;
    logic        es;
    logic [31:0] ed;
  } vec_t;

  logic        clk;
  logic        rst0, rst3;
  s_ahb_mosi_t mosi0, mosi3;
  s_ahb_miso_t miso0, miso3;
  int          total, bad, cyc;
  vec_t        tbl[27];

  ahb_mem_slave #(.MEM_WORDS(1024), .BASE_ADDR(Base), .WAIT_STATES(0)) dut0 (
    .hclk(clk), .hresetn(rst0), .ahb_mosi_i(mosi0), .ahb_miso_o(miso0)
  );

  ahb_mem_slave #(.MEM_WORDS(1024), .BASE_ADDR(Base), .WAIT_STATES(3)) dut3 (
    .hclk(clk), .hresetn(rst3), .ahb_mosi_i(mosi3), .ahb_miso_o(miso3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic sel, logic [1:0] tr, logic wr, logic [2:0] sz,
                              logic [31:0] a, logic [31:0] wd, logic er, logic es,
                              logic [31:0] ed);
    vec_t v;
    v.sel = sel; v.tr = tr; v.wr = wr; v.sz = sz; v.a = a; v.wd = wd;
    v.er = er; v.es = es; v.ed = ed;
    return v;
  endfunction

  function automatic vec_t idl(logic [31:0] wd, logic er, logic es, logic [31:0] ed);
    return mk(1'b0, TI, 1'b0, SW, 32'h0, wd, er, es, ed);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a rising edge: drive one bus cycle, check mid-cycle, advance.
  task automatic apply(input int d, input vec_t v);
    s_ahb_mosi_t m;
    s_ahb_miso_t r;
    m = '0;
    m.hsel = v.sel; m.htrans = v.tr; m.hwrite = v.wr; m.hsize = v.sz;
    m.haddr = v.a; m.hwdata = v.wd;
    if (d == 0) mosi0 = m;
    else mosi3 = m;
    @(negedge clk);
    r = (d == 0) ? miso0 : miso3;
    chk($sformatf("d%0d_c%0d_hready", d, cyc), {31'h0, r.hready}, {31'h0, v.er});
    chk($sformatf("d%0d_c%0d_hresp", d, cyc), {31'h0, r.hresp}, {31'h0, v.es});
    chk($sformatf("d%0d_c%0d_hrdata", d, cyc), r.hrdata, v.ed);
    chk($sformatf("d%0d_c%0d_hexokay", d, cyc), {31'h0, r.hexokay}, 32'h0);
    cyc++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    rst0 = 1'b0; rst3 = 1'b0;
    mosi0 = '0; mosi3 = '0;

    // Zero-wait pipelined traffic: write/read, byte lanes, errors, non-transfers.
    tbl[0]  = mk(1, TN, 1, SW, Base + 32'h8,  32'h0,         1, 0, 32'h0);
    tbl[1]  = mk(1, TS, 0, SW, Base + 32'h8,  32'hDEAD_BEEF, 1, 0, 32'h0);
    tbl[2]  = mk(1, TN, 1, SW, Base + 32'h10, 32'h0,         1, 0, 32'hDEAD_BEEF);
    tbl[3]  = mk(1, TN, 1, SB, Base + 32'h11, 32'h0,         1, 0, 32'h0);
    tbl[4]  = mk(1, TN, 1, SH, Base + 32'h12, 32'h0000_AA00, 1, 0, 32'h0);
    tbl[5]  = mk(1, TN, 0, SW, Base + 32'h10, 32'h1234_0000, 1, 0, 32'h0);
    tbl[6]  = mk(1, TN, 1, SW, Base,          32'h0,         1, 0, 32'h1234_AA00);
    tbl[7]  = mk(1, TN, 1, SW, Base + 32'h1000, 32'h5566_7788, 1, 0, 32'h0);
    tbl[8]  = idl(Ones, 0, 1, 32'h0);
    tbl[9]  = mk(1, TN, 1, SW, Base + 32'h2,  Ones,          1, 1, 32'h0);
    tbl[10] = idl(Ones, 0, 1, 32'h0);
    tbl[11] = mk(1, TN, 1, SD, Base,          Ones,          1, 1, 32'h0);
    tbl[12] = idl(Ones, 0, 1, 32'h0);
    tbl[13] = mk(1, TN, 0, SW, Base,          Ones,          1, 1, 32'h0);
    tbl[14] = idl(Ones, 1, 0, 32'h5566_7788);
    tbl[15] = mk(1, TN, 1, SW, Base - 32'h4,  Ones,          1, 0, 32'h0);
    tbl[16] = idl(Ones, 0, 1, 32'h0);
    tbl[17] = mk(1, TN, 1, SH, Base + 32'h1,  Ones,          1, 1, 32'h0);
    tbl[18] = idl(Ones, 0, 1, 32'h0);
    tbl[19] = idl(Ones, 1, 1, 32'h0);
    tbl[20] = mk(1, TN, 0, SW, Base,          Ones,          1, 0, 32'h0);
    tbl[21] = mk(1, TB, 1, SW, Base,          Ones,          1, 0, 32'h5566_7788);
    tbl[22] = mk(1, TI, 1, SW, Base,          Ones,          1, 0, 32'h0);
    tbl[23] = mk(0, TN, 1, SW, Base,          Ones,          1, 0, 32'h0);
    tbl[24] = idl(Ones, 1, 0, 32'h0);
    tbl[25] = mk(1, TN, 0, SW, Base,          Ones,          1, 0, 32'h0);
    tbl[26] = idl(Ones, 1, 0, 32'h5566_7788);

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst0_hready", {31'h0, miso0.hready}, 32'h1);
    chk("rst0_hresp", {31'h0, miso0.hresp}, 32'h0);
    chk("rst0_hrdata", miso0.hrdata, 32'h0);
    chk("rst3_hready", {31'h0, miso3.hready}, 32'h1);
    chk("rst3_hresp", {31'h0, miso3.hresp}, 32'h0);
    chk("rst3_hexokay", {31'h0, miso3.hexokay}, 32'h0);
    @(posedge clk);
    #1;
    rst0 = 1'b1; rst3 = 1'b1;

    for (int i = 0; i < 27; i++) apply(0, tbl[i]);

    // Three wait states: write, single read, then back-to-back reads every 4 cycles.
    apply(3, mk(1, TN, 1, SW, Base + 32'h4, 32'hCAFE_F00D, 1, 0, 32'h0));
    for (int i = 0; i < 3; i++) apply(3, idl(32'hCAFE_F00D, 0, 0, 32'h0));
    apply(3, mk(1, TN, 0, SW, Base + 32'h4, 32'hCAFE_F00D, 1, 0, 32'h0));
    for (int i = 0; i < 3; i++) apply(3, idl(32'h0, 0, 0, 32'h0));
    apply(3, mk(1, TN, 0, SW, Base + 32'h4, 32'h0, 1, 0, 32'hCAFE_F00D));
    for (int i = 0; i < 3; i++) apply(3, mk(1, TN, 0, SW, Base + 32'h4, 32'h0, 0, 0, 32'h0));
    apply(3, mk(1, TN, 0, SW, Base + 32'h4, 32'h0, 1, 0, 32'hCAFE_F00D));
    for (int i = 0; i < 3; i++) apply(3, idl(32'h0, 0, 0, 32'h0));
    apply(3, idl(32'h0, 1, 0, 32'hCAFE_F00D));
    apply(3, idl(32'h0, 1, 0, 32'h0));

    // Errors ignore wait states.
    apply(3, mk(1, TN, 1, SW, Base + 32'h2, 32'h0, 1, 0, 32'h0));
    apply(3, idl(Ones, 0, 1, 32'h0));
    apply(3, idl(Ones, 1, 1, 32'h0));
    apply(3, idl(Ones, 1, 0, 32'h0));

    // Reset during the wait states of a write discards it.
    apply(3, mk(1, TN, 1, SW, Base + 32'h4, 32'h0, 1, 0, 32'h0));
    rst3 = 1'b0;
    apply(3, idl(32'h0, 0, 0, 32'h0));
    rst3 = 1'b1;
    for (int i = 0; i < 4; i++) apply(3, idl(32'h0, 1, 0, 32'h0));
    apply(3, mk(1, TN, 0, SW, Base + 32'h4, 32'h0, 1, 0, 32'h0));
    for (int i = 0; i < 3; i++) apply(3, idl(32'h0, 0, 0, 32'h0));
    apply(3, idl(32'h0, 1, 0, 32'hCAFE_F00D));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
